// File: rtl/rally_score_if.sv
// Signal bundle between the ball controller side (master) and the rally referee (slave).
// Parameterised by SCORE_W so the score buses match the referee's counter width.
interface rally_score_if #(
    parameter int SCORE_W = 5
);
    // Signalling: new_game is a 1-cycle pulse; *_col are levels whose rising edges are events;
    // point_stb is a 1-cycle pulse; every other referee output is a registered level.
    logic               new_game;
    logic               pl1_col;
    logic               pl2_col;
    logic               gnd_col;
    logic [11:0]        ball_posx;
    logic               ovr_touch;
    logic [SCORE_W-1:0] pl1_score;
    logic [SCORE_W-1:0] pl2_score;
    logic               point_stb;
    logic               point_to;
    logic               serve_pl;
    logic               rally_act;
    logic               game_over;
    logic               winner;

    modport master (
        output new_game, pl1_col, pl2_col, gnd_col, ball_posx,
        input  ovr_touch, pl1_score, pl2_score, point_stb, point_to,
               serve_pl, rally_act, game_over, winner
    );

    modport slave (
        input  new_game, pl1_col, pl2_col, gnd_col, ball_posx,
        output ovr_touch, pl1_score, pl2_score, point_stb, point_to,
               serve_pl, rally_act, game_over, winner
    );
endinterface

// File: rtl/rally_score_ctrl.sv
// Rally referee: counts touches per side, awards points, tracks serve and declares game over.
// Optional macro WIN_BY_TWO_EN switches the win rule to "reach WIN_SCORE with a lead of two".
module rally_score_ctrl #(
    parameter int MAX_TOUCH   = 3,
    parameter int WIN_SCORE   = 15,
    parameter int SCORE_W     = 5,
    parameter int NET_X       = 512,
    parameter int BALL_HALF   = 32,
    parameter int HOLD_CYCLES = 162_500_000
) (
    input  logic         clk,
    input  logic         rst,
    rally_score_if.slave bus,
    output logic [1:0]   dbg_state
);

    localparam int HOLD_W = 28;
    localparam int TW     = $clog2(MAX_TOUCH + 2);
    localparam logic [TW-1:0]     TOUCH_FAULT = TW'(MAX_TOUCH + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        RALLY     = 2'd1,
        SCORED    = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       t1_q, t1_d, t2_q, t2_d;
    logic [SCORE_W-1:0]  s1_q, s1_d, s2_q, s2_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic                ovr_q, ovr_d;
    logic                point_stb_q, point_stb_d;
    logic                point_to_q, point_to_d;
    logic                serve_q, serve_d;
    logic                winner_q, winner_d;
    logic                c1_q, c2_q, cg_q;
    logic                e1_q, e1_d, e2_q, e2_d, eg_q, eg_d;
    logic [11:0]         posx_q;
    logic                award, award_to, ground_pl1, win_now;

    function automatic logic win_check(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
`ifdef WIN_BY_TWO_EN
        logic [SCORE_W:0] aw;
        logic [SCORE_W:0] bw;
        aw = {1'b0, a};
        bw = {1'b0, b};
        return ((aw >= (SCORE_W+1)'(WIN_SCORE)) && (aw >= bw + (SCORE_W+1)'(2))) ||
               ((bw >= (SCORE_W+1)'(WIN_SCORE)) && (bw >= aw + (SCORE_W+1)'(2)));
`else
        return (a == SCORE_W'(WIN_SCORE)) || (b == SCORE_W'(WIN_SCORE));
`endif
    endfunction

    // Edges are registered once more so input-to-point latency is two cycles.
    assign e1_d = bus.pl1_col & ~c1_q;
    assign e2_d = bus.pl2_col & ~c2_q;
    assign eg_d = bus.gnd_col & ~cg_q;

    assign ground_pl1 = ({1'b0, posx_q} + 13'(BALL_HALF)) < 13'(NET_X);
    assign win_now    = win_check(s1_q, s2_q);

    always_comb begin
        state_d     = state_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        cnt_d       = cnt_q;
        ovr_d       = ovr_q;
        point_stb_d = 1'b0;
        point_to_d  = point_to_q;
        serve_d     = serve_q;
        winner_d    = winner_q;
        award       = 1'b0;
        award_to    = 1'b0;

        if (bus.new_game) begin
            state_d  = SERVE;
            t1_d     = '0;
            t2_d     = '0;
            s1_d     = '0;
            s2_d     = '0;
            cnt_d    = '0;
            ovr_d    = 1'b0;
            serve_d  = 1'b0;
            winner_d = 1'b0;
        end else begin
            case (state_q)
                SERVE: begin
                    if (e1_q) begin
                        state_d = RALLY;
                        t1_d    = TW'(1);
                        t2_d    = '0;
                    end else if (e2_q) begin
                        state_d = RALLY;
                        t1_d    = '0;
                        t2_d    = TW'(1);
                    end
                end
                RALLY: begin
                    // Ground contact outranks any touch arriving in the same cycle.
                    if (eg_q) begin
                        award    = 1'b1;
                        award_to = ground_pl1;
                    end else if (e1_q) begin
                        t1_d = (t1_q == TOUCH_FAULT) ? t1_q : t1_q + TW'(1);
                        t2_d = '0;
                        if (t1_d == TOUCH_FAULT) begin
                            ovr_d    = 1'b1;
                            award    = 1'b1;
                            award_to = 1'b1;
                        end
                    end else if (e2_q) begin
                        t2_d = (t2_q == TOUCH_FAULT) ? t2_q : t2_q + TW'(1);
                        t1_d = '0;
                        if (t2_d == TOUCH_FAULT) begin
                            ovr_d    = 1'b1;
                            award    = 1'b1;
                            award_to = 1'b0;
                        end
                    end
                    if (award) begin
                        point_stb_d = 1'b1;
                        point_to_d  = award_to;
                        serve_d     = award_to;
                        state_d     = SCORED;
                        cnt_d       = '0;
                        if (award_to) begin
                            s2_d = (s2_q == '1) ? s2_q : s2_q + SCORE_W'(1);
                        end else begin
                            s1_d = (s1_q == '1) ? s1_q : s1_q + SCORE_W'(1);
                        end
                    end
                end
                SCORED: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = '0;
                        t1_d  = '0;
                        t2_d  = '0;
                        ovr_d = 1'b0;
                        if (win_now) begin
                            state_d  = GAME_OVER;
                            winner_d = (s2_q > s1_q);
                        end else begin
                            state_d = SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + HOLD_W'(1);
                    end
                end
                GAME_OVER: begin
                    state_d = GAME_OVER;
                end
                default: state_d = SERVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SERVE;
            t1_q        <= '0;
            t2_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
            point_stb_q <= 1'b0;
            point_to_q  <= 1'b0;
            serve_q     <= 1'b0;
            winner_q    <= 1'b0;
            // Load live levels so a collision held across reset release is not an edge.
            c1_q        <= bus.pl1_col;
            c2_q        <= bus.pl2_col;
            cg_q        <= bus.gnd_col;
            e1_q        <= 1'b0;
            e2_q        <= 1'b0;
            eg_q        <= 1'b0;
            posx_q      <= bus.ball_posx;
        end else begin
            state_q     <= state_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            cnt_q       <= cnt_d;
            ovr_q       <= ovr_d;
            point_stb_q <= point_stb_d;
            point_to_q  <= point_to_d;
            serve_q     <= serve_d;
            winner_q    <= winner_d;
            c1_q        <= bus.pl1_col;
            c2_q        <= bus.pl2_col;
            cg_q        <= bus.gnd_col;
            e1_q        <= e1_d;
            e2_q        <= e2_d;
            eg_q        <= eg_d;
            posx_q      <= bus.ball_posx;
        end
    end

    assign bus.ovr_touch = ovr_q;
    assign bus.pl1_score = s1_q;
    assign bus.pl2_score = s2_q;
    assign bus.point_stb = point_stb_q;
    assign bus.point_to  = point_to_q;
    assign bus.serve_pl  = serve_q;
    assign bus.rally_act = (state_q == RALLY);
    assign bus.game_over = (state_q == GAME_OVER);
    assign bus.winner    = winner_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_rally_score_ctrl.sv
// Bench for rally_score_ctrl with a short hold and a low winning score.
// Reference model works at rally-event level: touches, ground hits, points and the win rule.
module tb_rally_score_ctrl;

    localparam int SW   = 5;
    localparam int WIN  = 3;
    localparam int HOLD = 4;
    localparam int MAXT = 3;
    localparam logic [1:0] ST_SERVE  = 2'd0;
    localparam logic [1:0] ST_RALLY  = 2'd1;
    localparam logic [1:0] ST_SCORED = 2'd2;
    localparam logic [1:0] ST_OVER   = 2'd3;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    rally_score_if #(.SCORE_W(SW)) bus();

    rally_score_ctrl #(
        .MAX_TOUCH(MAXT), .WIN_SCORE(WIN), .SCORE_W(SW),
        .NET_X(512), .BALL_HALF(32), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Event-level model of the match
    bit m_in_rally;
    bit m_over;
    int m_t[2];
    int m_s[2];
    int m_serve;

    logic [0:0] exp_q[$];

    int   obs_stb;
    int   obs_lat;
    int   obs_hold;
    logic obs_ovr;
    logic obs_to;
    int   exp_pt;
    bit   exp_fault;

    function automatic bit model_win(input int a, input int b);
`ifdef WIN_BY_TWO_EN
        return (a >= WIN && a - b >= 2) || (b >= WIN && b - a >= 2);
`else
        return (a == WIN) || (b == WIN);
`endif
    endfunction

    task automatic model_reset();
        m_in_rally = 0; m_over = 0; m_serve = 0;
        m_t[0] = 0; m_t[1] = 0; m_s[0] = 0; m_s[1] = 0;
    endtask

    // kind: 0 pl1 touch, 1 pl2 touch, 2 ground, 3 ground+pl1, 4 pl1+pl2
    task automatic model_event(input int kind, input int posx, output int pt, output bit fault);
        int side;
        bit ground;
        bit touch;
        pt = -1;
        fault = 0;
        ground = (kind == 2 || kind == 3);
        touch = (kind != 2);
        side = (kind == 1) ? 1 : 0;
        if (m_over) return;
        if (!m_in_rally) begin
            if (touch) begin
                m_in_rally = 1;
                m_t[side] = 1;
                m_t[1-side] = 0;
            end
            return;
        end
        if (ground) begin
            pt = (posx + 32 < 512) ? 1 : 0;
        end else begin
            m_t[side] = (m_t[side] + 1 > MAXT + 1) ? MAXT + 1 : m_t[side] + 1;
            m_t[1-side] = 0;
            if (m_t[side] == MAXT + 1) begin
                pt = 1 - side;
                fault = 1;
            end
        end
        if (pt >= 0) begin
            m_s[pt] = (m_s[pt] == 31) ? 31 : m_s[pt] + 1;
            m_serve = pt;
            m_in_rally = 0;
            m_t[0] = 0; m_t[1] = 0;
            m_over = model_win(m_s[0], m_s[1]);
        end
    endtask

    // Drive one event as a one-cycle level pulse and record what the referee did.
    task automatic do_event(input int kind, input logic [11:0] posx);
        int guard;
        @(posedge clk); #1;
        bus.ball_posx = posx;
        bus.pl1_col = (kind == 0 || kind == 3 || kind == 4);
        bus.pl2_col = (kind == 1 || kind == 4);
        bus.gnd_col = (kind == 2 || kind == 3);
        @(posedge clk); #1;
        bus.pl1_col = 1'b0; bus.pl2_col = 1'b0; bus.gnd_col = 1'b0;
        obs_stb = 0; obs_lat = 0; obs_hold = 0; obs_ovr = 1'b0; obs_to = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (bus.point_stb) begin
                obs_stb++; obs_lat = i; obs_ovr = bus.ovr_touch; obs_to = bus.point_to;
            end
            if (dbg_state == ST_SCORED) obs_hold++;
        end
        guard = 0;
        while (dbg_state == ST_SCORED && guard < 20) begin
            @(negedge clk);
            if (dbg_state == ST_SCORED) obs_hold++;
            if (bus.point_stb) obs_stb++;
            guard++;
        end
    endtask

    task automatic ev(input int kind, input logic [11:0] posx);
        model_event(kind, int'(posx), exp_pt, exp_fault);
        do_event(kind, posx);
    endtask

    task automatic do_new_game();
        @(posedge clk); #1 bus.new_game = 1'b1;
        @(posedge clk); #1 bus.new_game = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.new_game = 1'b0; bus.pl1_col = 1'b1; bus.pl2_col = 1'b0; bus.gnd_col = 1'b0;
        bus.ball_posx = 12'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.pl1_score !== 5'd0) begin n_errors++; $display("FAIL rst_pl1_score: got %0d want 0", bus.pl1_score); end
        n_checks++; if (bus.pl2_score !== 5'd0) begin n_errors++; $display("FAIL rst_pl2_score: got %0d want 0", bus.pl2_score); end
        n_checks++; if ({bus.ovr_touch, bus.point_stb, bus.point_to, bus.serve_pl} !== 4'b0)
            begin n_errors++; $display("FAIL rst_flags: got %b want 0000", {bus.ovr_touch, bus.point_stb, bus.point_to, bus.serve_pl}); end
        n_checks++; if ({bus.rally_act, bus.game_over, bus.winner} !== 3'b0)
            begin n_errors++; $display("FAIL rst_status: got %b want 000", {bus.rally_act, bus.game_over, bus.winner}); end
        n_checks++; if (dbg_state !== ST_SERVE) begin n_errors++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_SERVE); end
        repeat (3) @(negedge clk);
        n_checks++; if (bus.rally_act !== 1'b0) begin n_errors++; $display("FAIL rst_no_edge: rally_act got %b want 0", bus.rally_act); end
        bus.pl1_col = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
    endtask

    task automatic test_ground_point();
        do_new_game();
        ev(0, 12'd0);
        n_checks++; if (bus.rally_act !== 1'b1) begin n_errors++; $display("FAIL gp_rally: got %b want 1", bus.rally_act); end
        ev(2, 12'd100);
        n_checks++; if (obs_stb !== 1) begin n_errors++; $display("FAIL gp_stb_count: got %0d want 1", obs_stb); end
        n_checks++; if (obs_lat !== 2) begin n_errors++; $display("FAIL gp_latency: got %0d want 2", obs_lat); end
        n_checks++; if (bus.pl2_score !== 5'd1 || bus.pl1_score !== 5'd0)
            begin n_errors++; $display("FAIL gp_score: got %0d-%0d want 0-1", bus.pl1_score, bus.pl2_score); end
        n_checks++; if (bus.serve_pl !== 1'b1 || obs_to !== 1'b1)
            begin n_errors++; $display("FAIL gp_serve: serve %b to %b want 1 1", bus.serve_pl, obs_to); end
        n_checks++; if (obs_hold !== HOLD) begin n_errors++; $display("FAIL gp_hold: got %0d want %0d", obs_hold, HOLD); end
        n_checks++; if (dbg_state !== ST_SERVE) begin n_errors++; $display("FAIL gp_back_serve: got %0d want %0d", dbg_state, ST_SERVE); end
        ev(2, 12'd100);
        n_checks++; if (obs_stb !== 0 || bus.rally_act !== 1'b0)
            begin n_errors++; $display("FAIL gp_gnd_in_serve: stb %0d rally %b want 0 0", obs_stb, bus.rally_act); end
        ev(1, 12'd0);
        ev(2, 12'd479);
        n_checks++; if (obs_stb !== 1 || obs_to !== 1'b1 || bus.pl2_score !== 5'd2)
            begin n_errors++; $display("FAIL gp_edge_479: stb %0d to %b pl2 %0d want 1 1 2", obs_stb, obs_to, bus.pl2_score); end
        ev(0, 12'd0);
        ev(2, 12'd480);
        n_checks++; if (obs_stb !== 1 || obs_to !== 1'b0 || bus.pl1_score !== 5'd1)
            begin n_errors++; $display("FAIL gp_edge_480: stb %0d to %b pl1 %0d want 1 0 1", obs_stb, obs_to, bus.pl1_score); end
        ev(0, 12'd0);
        ev(3, 12'd800);
        n_checks++; if (obs_stb !== 1 || obs_to !== 1'b0 || bus.pl1_score !== 5'd2)
            begin n_errors++; $display("FAIL gp_gnd_beats_touch: stb %0d to %b pl1 %0d want 1 0 2", obs_stb, obs_to, bus.pl1_score); end
    endtask

    task automatic test_touch_fault();
        do_new_game();
        for (int i = 0; i < 3; i++) begin
            ev(0, 12'd0);
            n_checks++; if (obs_stb !== 0 || bus.ovr_touch !== 1'b0)
                begin n_errors++; $display("FAIL tf_early_%0d: stb %0d ovr %b want 0 0", i, obs_stb, bus.ovr_touch); end
        end
        ev(0, 12'd0);
        n_checks++; if (obs_stb !== 1 || obs_ovr !== 1'b1)
            begin n_errors++; $display("FAIL tf_fault: stb %0d ovr %b want 1 1", obs_stb, obs_ovr); end
        n_checks++; if (bus.pl2_score !== 5'd1 || bus.pl1_score !== 5'd0)
            begin n_errors++; $display("FAIL tf_score: got %0d-%0d want 0-1", bus.pl1_score, bus.pl2_score); end
        n_checks++; if (bus.ovr_touch !== 1'b0) begin n_errors++; $display("FAIL tf_ovr_clear: got %b want 0", bus.ovr_touch); end
    endtask

    task automatic test_touch_reset();
        int pts;
        do_new_game();
        pts = 0;
        for (int i = 0; i < 3; i++) begin ev(0, 12'd0); pts += obs_stb; end
        ev(1, 12'd0); pts += obs_stb;
        for (int i = 0; i < 3; i++) begin ev(0, 12'd0); pts += obs_stb; end
        n_checks++; if (pts !== 0 || bus.ovr_touch !== 1'b0)
            begin n_errors++; $display("FAIL tr_no_fault: points %0d ovr %b want 0 0", pts, bus.ovr_touch); end
        n_checks++; if (bus.rally_act !== 1'b1) begin n_errors++; $display("FAIL tr_rally: got %b want 1", bus.rally_act); end
        ev(2, 12'd900);
    endtask

    task automatic test_simultaneous();
        do_new_game();
        ev(4, 12'd0);
        n_checks++; if (bus.rally_act !== 1'b1) begin n_errors++; $display("FAIL sim_rally: got %b want 1", bus.rally_act); end
        ev(0, 12'd0);
        ev(0, 12'd0);
        n_checks++; if (obs_stb !== 0) begin n_errors++; $display("FAIL sim_early: stb %0d want 0", obs_stb); end
        ev(0, 12'd0);
        n_checks++; if (obs_stb !== 1 || obs_ovr !== 1'b1 || bus.pl2_score !== 5'd1)
            begin n_errors++; $display("FAIL sim_pl1_count: stb %0d ovr %b pl2 %0d want 1 1 1", obs_stb, obs_ovr, bus.pl2_score); end
    endtask

    task automatic test_win();
        do_new_game();
        for (int i = 0; i < 2; i++) begin ev(0, 12'd0); ev(2, 12'd100); end
        for (int i = 0; i < 2; i++) begin ev(1, 12'd0); ev(2, 12'd800); end
        n_checks++; if (bus.pl1_score !== 5'd2 || bus.pl2_score !== 5'd2 || bus.game_over !== 1'b0)
            begin n_errors++; $display("FAIL win_deuce: got %0d-%0d over %b want 2-2 0", bus.pl1_score, bus.pl2_score, bus.game_over); end
        ev(1, 12'd0); ev(2, 12'd800);
`ifdef WIN_BY_TWO_EN
        n_checks++; if (bus.game_over !== 1'b0 || dbg_state !== ST_SERVE)
            begin n_errors++; $display("FAIL win_3_2: over %b state %0d want 0 %0d", bus.game_over, dbg_state, ST_SERVE); end
        ev(1, 12'd0); ev(2, 12'd800);
        n_checks++; if (bus.pl1_score !== 5'd4) begin n_errors++; $display("FAIL win_pl1_4: got %0d want 4", bus.pl1_score); end
`else
        n_checks++; if (bus.pl1_score !== 5'd3) begin n_errors++; $display("FAIL win_pl1_3: got %0d want 3", bus.pl1_score); end
`endif
        n_checks++; if (bus.game_over !== 1'b1 || bus.winner !== 1'b0 || dbg_state !== ST_OVER)
            begin n_errors++; $display("FAIL win_over: over %b winner %b state %0d want 1 0 %0d", bus.game_over, bus.winner, dbg_state, ST_OVER); end
        ev(1, 12'd0);
        n_checks++; if (bus.rally_act !== 1'b0 || obs_stb !== 0 || bus.pl2_score !== 5'd2)
            begin n_errors++; $display("FAIL win_frozen: rally %b stb %0d pl2 %0d want 0 0 2", bus.rally_act, obs_stb, bus.pl2_score); end
    endtask

    task automatic test_new_game();
        int stb_seen;
        do_new_game();
        for (int i = 0; i < 2; i++) begin ev(1, 12'd0); ev(2, 12'd800); end
        ev(0, 12'd0); ev(2, 12'd100);
        ev(0, 12'd0);
        n_checks++; if (bus.pl1_score !== 5'd2 || bus.pl2_score !== 5'd1 || bus.rally_act !== 1'b1)
            begin n_errors++; $display("FAIL ng_setup: %0d-%0d rally %b want 2-1 1", bus.pl1_score, bus.pl2_score, bus.rally_act); end
        @(posedge clk); #1;
        bus.new_game = 1'b1; bus.gnd_col = 1'b1; bus.ball_posx = 12'd100;
        @(posedge clk); #1;
        bus.new_game = 1'b0; bus.gnd_col = 1'b0;
        stb_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.point_stb) stb_seen++;
        end
        model_reset();
        n_checks++; if (stb_seen !== 0) begin n_errors++; $display("FAIL ng_no_stb: got %0d want 0", stb_seen); end
        n_checks++; if (bus.pl1_score !== 5'd0 || bus.pl2_score !== 5'd0)
            begin n_errors++; $display("FAIL ng_scores: got %0d-%0d want 0-0", bus.pl1_score, bus.pl2_score); end
        n_checks++; if (bus.ovr_touch !== 1'b0 || bus.serve_pl !== 1'b0 || dbg_state !== ST_SERVE)
            begin n_errors++; $display("FAIL ng_state: ovr %b serve %b state %0d want 0 0 %0d", bus.ovr_touch, bus.serve_pl, dbg_state, ST_SERVE); end
    endtask

    task automatic test_random();
        int kind;
        int r;
        logic [11:0] posx;
        logic [0:0] want_to;
        do_new_game();
        exp_q.delete();
        for (int n = 0; n < 120; n++) begin
            if (m_over) do_new_game();
            r = $urandom_range(0, 19);
            if (r < 8) kind = 0;
            else if (r < 15) kind = 1;
            else if (r < 18) kind = 2;
            else if (r == 18) kind = 3;
            else kind = 4;
            r = $urandom_range(0, 9);
            posx = (r == 0) ? 12'd479 : (r == 1) ? 12'd480 : (r == 2) ? 12'd4095 : 12'($urandom_range(0, 1100));
            model_event(kind, int'(posx), exp_pt, exp_fault);
            if (exp_pt >= 0) exp_q.push_back(exp_pt[0:0]);
            do_event(kind, posx);
            n_checks++; if (obs_stb !== ((exp_pt >= 0) ? 1 : 0))
                begin n_errors++; $display("FAIL rnd_stb_%0d: got %0d want %0d (kind %0d posx %0d)", n, obs_stb, (exp_pt >= 0) ? 1 : 0, kind, posx); end
            if (obs_stb > 0 && exp_q.size() > 0) begin
                want_to = exp_q.pop_front();
                n_checks++; if (obs_to !== want_to || obs_ovr !== exp_fault)
                    begin n_errors++; $display("FAIL rnd_point_%0d: to %b ovr %b want %b %b", n, obs_to, obs_ovr, want_to, exp_fault); end
                n_checks++; if (obs_hold !== HOLD) begin n_errors++; $display("FAIL rnd_hold_%0d: got %0d want %0d", n, obs_hold, HOLD); end
            end
            n_checks++; if (bus.pl1_score !== SW'(m_s[0]) || bus.pl2_score !== SW'(m_s[1]))
                begin n_errors++; $display("FAIL rnd_score_%0d: got %0d-%0d want %0d-%0d", n, bus.pl1_score, bus.pl2_score, m_s[0], m_s[1]); end
            n_checks++; if (bus.serve_pl !== 1'(m_serve) || bus.rally_act !== m_in_rally || bus.game_over !== m_over || bus.ovr_touch !== 1'b0)
                begin n_errors++; $display("FAIL rnd_status_%0d: serve %b rally %b over %b ovr %b want %0d %b %b 0", n, bus.serve_pl, bus.rally_act, bus.game_over, bus.ovr_touch, m_serve, m_in_rally, m_over); end
            if (m_over) begin
                n_checks++; if (bus.winner !== (m_s[1] > m_s[0]))
                    begin n_errors++; $display("FAIL rnd_winner_%0d: got %b want %b", n, bus.winner, (m_s[1] > m_s[0])); end
            end
        end
        n_checks++; if (exp_q.size() !== 0) begin n_errors++; $display("FAIL rnd_queue: %0d points never seen, want 0", exp_q.size()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ground_point();
        test_touch_fault();
        test_touch_reset();
        test_simultaneous();
        test_win();
        test_new_game();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
